// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a valid/ready handshake, an optional skid
// entry and a synchronous flush. Sits between CPU pipeline stages so that
// back-pressure and squash are handled here rather than by ad-hoc enables.
//
// The number of held entries doubles as the state: EMPTY, ONE or TWO.
// The second (skid) entry only exists when skid != 0; it lets in_ready come
// straight from a flop so that out_ready never reaches in_ready through
// logic. With skid == 0 the stage is a single entry and in_ready is
// combinational, which still sustains one transfer per cycle.
module pipe_stage_reg #(
    parameter int                width       = 32,
    parameter logic [width-1:0]  reset_value = '0,
    parameter int                skid        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [width-1:0] main_q;
    logic [width-1:0] main_d;
    logic [width-1:0] skid_q;
    logic [width-1:0] skid_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (skid != 0) begin : g_registered_ready
            logic ready_q;

            // Ready is precomputed from the next occupancy so it never depends on out_ready this cycle
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != TWO);
                end
            end

            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // Next occupancy and entry contents; flush wins over everything and drops a same-cycle input
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = reset_value;
            skid_d  = reset_value;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry; the single-entry ready blocks this case
                        if (skid != 0) begin
                            state_d = TWO;
                            skid_d  = in_data;
                        end
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = reset_value;
                    skid_d  = reset_value;
                end
            endcase
        end
    end

    // State and data registers; reset empties the stage immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= reset_value;
            skid_q  <= reset_value;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg. Both the skid and the single-entry
// variant see the same input stream; each has its own reference FIFO whose
// capacity and ready rule come straight from the handshake definition.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic [1:0]  in_ready_w;
    logic [1:0]  out_valid_w;
    logic [31:0] out_data_w [2];
    logic [1:0]  occ_w [2];

    int checks = 0;
    int errors = 0;

    // Reference model: per variant a FIFO (entries, count) plus the value
    // shown on out_data while empty.
    int          cnt [2];
    logic [31:0] ent [2][2];
    logic [31:0] idle [2];
    bit          pred_ready [2];

    pipe_stage_reg #(.width(32), .reset_value(RV), .skid(1)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
        .occupancy(occ_w[1])
    );

    pipe_stage_reg #(.width(32), .reset_value(RV), .skid(0)) dut_plain (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
        .occupancy(occ_w[0])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Monitor: mid-cycle, compare outputs with the model and retire whatever downstream takes
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    bit          exp_ready;
                    logic [31:0] exp_data;
                    logic [31:0] last;
                    exp_ready = (d == 1) ? (cnt[d] != 2) : ((cnt[d] == 0) || out_ready);
                    exp_data  = (cnt[d] != 0) ? ent[d][0] : idle[d];
                    checkOutput($sformatf("v%0d_in_ready", d), {31'b0, in_ready_w[d]}, {31'b0, exp_ready});
                    checkOutput($sformatf("v%0d_out_valid", d), {31'b0, out_valid_w[d]}, {31'b0, (cnt[d] != 0)});
                    checkOutput($sformatf("v%0d_occupancy", d), {30'b0, occ_w[d]}, cnt[d]);
                    checkOutput($sformatf("v%0d_out_data", d), out_data_w[d], exp_data);
                    pred_ready[d] = exp_ready;
                    if (cnt[d] != 0 && out_ready) begin
                        last       = ent[d][0];
                        ent[d][0]  = ent[d][1];
                        cnt[d]     = cnt[d] - 1;
                        if (cnt[d] == 0) idle[d] = last;
                    end
                end
            end
        end
    end

    // Scoreboard update at the clock edge: reset/flush empty the FIFO, accepted inputs are queued
    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    cnt[d]        = 0;
                    idle[d]       = RV;
                    pred_ready[d] = 1'b0;
                end else if (flush) begin
                    cnt[d]  = 0;
                    idle[d] = RV;
                end else if (in_valid && pred_ready[d]) begin
                    ent[d][cnt[d]] = in_data;
                    cnt[d]         = cnt[d] + 1;
                end
            end
        end
    end

    initial begin
        // Power-on reset, checked before any clock edge
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("v%0d_por_out_valid", d), {31'b0, out_valid_w[d]}, 32'd0);
            checkOutput($sformatf("v%0d_por_occupancy", d), {30'b0, occ_w[d]}, 32'd0);
            checkOutput($sformatf("v%0d_por_out_data", d), out_data_w[d], RV);
            checkOutput($sformatf("v%0d_por_in_ready", d), {31'b0, in_ready_w[d]}, 32'd1);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Streaming with downstream always ready
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0,  1'b1, 1'b0);

        // Back-pressure then release
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with the skid variant full
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        checkOutput("pre_reset_occupancy", {30'b0, occ_w[1]}, 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_out_valid", {31'b0, out_valid_w[1]}, 32'd0);
        checkOutput("mid_reset_occupancy", {30'b0, occ_w[1]}, 32'd0);
        checkOutput("mid_reset_out_data", out_data_w[1], RV);
        checkOutput("mid_reset_in_ready", {31'b0, in_ready_w[1]}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("post_reset_in_ready_skid", {31'b0, in_ready_w[1]}, 32'd1);
        checkOutput("post_reset_in_ready_plain", {31'b0, in_ready_w[0]}, 32'd1);

        // Flush while full, with a simultaneous input that must be dropped
        applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h6, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h7, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Combinational ready on the single-entry variant
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h9, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes
        repeat (1500) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        // Drain
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register with a valid/ready handshake, an optional skid entry and a synchronous flush.
- Successor to the plain enable register. Used between CPU pipeline stages (IF/ID, ID/EX, ...) so that back-pressure and squash are handled inside the stage register instead of through ad-hoc enable logic.
- Sustains one transfer per cycle with one cycle of latency.

Parameters:
- width, 32, payload width in bits.
- reset_value, 0, value loaded into every data register on reset and on flush.
- skid, 1. When 1: two entries (main + skid) and `in_ready` is driven straight from a flop. When 0: one entry and `in_ready` is combinational.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept data.
- in_data  input  width  upstream payload.
- out_valid  output  1  stage holds data for downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  width  payload of the main entry.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Reset (rst=0, asynchronous, independent of clk):
  - out_valid=0, out_data=reset_value, skid entry empty with data=reset_value.
  - occupancy=0.
  - in_ready=1 while held in reset and after release.
- State is encoded by occupancy: EMPTY(0), ONE(1), TWO(2). TWO exists only when skid=1.
- out_valid = (occupancy != 0). out_data is always the main entry.
- in_ready:
  - skid=1: in_ready = (occupancy != 2), registered; no combinational path from out_ready.
  - skid=0: in_ready = ~out_valid | out_ready, combinational.
- Transitions on the rising edge, when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay.
  - ONE, in_fire & out_fire -> ONE, main<=in_data.
  - ONE, in_fire & ~out_fire:
    - skid=1: -> TWO, skid<=in_data.
    - skid=0: this case cannot occur.
  - ONE, ~in_fire & out_fire -> EMPTY. main data is left unchanged.
  - ONE, neither fire -> stay, data stable.
  - TWO: in_ready=0. out_fire -> ONE, main<=skid data. Otherwise hold both entries.
- Ordering: data leaves in strict FIFO order. No duplication, no loss except by flush.
- Flush (synchronous, highest priority):
  - Next state is EMPTY and both data registers are loaded with reset_value.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle still counts as consumed by downstream.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N when the stage was EMPTY or draining.
- Throughput: one item per cycle with out_ready held high, for both skid settings.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
- Reset mid-transfer: any held entries are discarded immediately. No partial update.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.

Test Plan:
- Reset behaviour: assert rst=0 mid-stream with occupancy=2 -> out_valid=0, occupancy=0, out_data=reset_value immediately (before the next clk edge); in_ready=1 after release.
- Streaming (skid=1, width=32): out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 on the next three cycles; in_ready stays 1 throughout.
- Back-pressure: hold out_ready=0, push 0xA then 0xB -> occupancy=2 and in_ready=0; 0xC is held off. Release out_ready -> outputs 0xA, then 0xB, then 0xC, with no loss or duplication.
- Flush: occupancy=2 holding 0x5,0x6; pulse flush with in_valid=1, in_data=0x7 -> next cycle occupancy=0, out_valid=0, out_data=reset_value; 0x7 never appears.
- Simultaneous fire in ONE: main=0x1, in_data=0x2 with both in_fire and out_fire -> occupancy stays 1 and out_data=0x2.
- skid=0 variant: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; raising out_ready -> in_ready=1 combinationally, and a new item is accepted that cycle.
